// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALU-op encodings, control-bundle bit positions.
// Used by decode_id and its register file.
package pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Bit positions inside the wb {reg_write, mem_to_reg}, m {branch, mem_read, mem_write}
    // and ex {reg_dst, alu_op[1:0], alu_src} bundles.
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;
    localparam int M_BRANCH      = 2;
    localparam int M_MEM_READ    = 1;
    localparam int M_MEM_WRITE   = 0;
    localparam int EX_REG_DST    = 3;
    localparam int EX_ALU_OP_HI  = 2;
    localparam int EX_ALU_OP_LO  = 1;
    localparam int EX_ALU_SRC    = 0;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/decode_id_if.sv
// Bundle of IF/ID, MEM/WB writeback and ID/EX signals around the decode stage.
// slave = decode stage, master = surrounding pipeline.
interface decode_id_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic [31:0]           if_id_instr;
    logic [DATA_W-1:0]     if_id_npc;
    logic                  id_ex_flush;
    logic                  mem_wb_reg_write;
    logic [REG_ADDR_W-1:0] mem_wb_write_reg;
    logic [DATA_W-1:0]     mem_wb_write_data;
    logic [1:0]            id_ex_wb;
    logic [2:0]            id_ex_m;
    logic [3:0]            id_ex_ex;
    logic [DATA_W-1:0]     id_ex_npc;
    logic [DATA_W-1:0]     id_ex_rd1;
    logic [DATA_W-1:0]     id_ex_rd2;
    logic [DATA_W-1:0]     id_ex_sign_ext;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic [REG_ADDR_W-1:0] id_ex_rd;

    modport master (
        output if_id_instr, if_id_npc, id_ex_flush,
               mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
        input  id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_rd1, id_ex_rd2,
               id_ex_sign_ext, id_ex_rt, id_ex_rd
    );

    modport slave (
        input  if_id_instr, if_id_npc, id_ex_flush,
               mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
        output id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_rd1, id_ex_rd2,
               id_ex_sign_ext, id_ex_rt, id_ex_rd
    );
endinterface

// File: rtl/reg_file.sv
// 32x32 register file: two combinational reads, one synchronous write, $0 hardwired to zero.
// Optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN.
module reg_file
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              wr_ok_s;

    // Qualified write enable: index 0 never takes a write.
    always_comb begin
        wr_ok_s = we && (waddr != {REG_ADDR_W{1'b0}});
    end

    // Register array with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port 1.
    always_comb begin
        rdata1 = {DATA_W{1'b0}};
        if (raddr1 == {REG_ADDR_W{1'b0}}) begin
            rdata1 = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (wr_ok_s && (waddr == raddr1)) begin
            rdata1 = wdata;
`endif
        end else begin
            rdata1 = regs_r[raddr1];
        end
    end

    // Read port 2.
    always_comb begin
        rdata2 = {DATA_W{1'b0}};
        if (raddr2 == {REG_ADDR_W{1'b0}}) begin
            rdata2 = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
        end else if (wr_ok_s && (waddr == raddr2)) begin
            rdata2 = wdata;
`endif
        end else begin
            rdata2 = regs_r[raddr2];
        end
    end

endmodule

// File: rtl/decode_id.sv
// Instruction-decode stage: control decoder, sign extender, register file and ID/EX latch.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module decode_id
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    decode_id_if.slave  bus
);

    logic [5:0]        opcode_s;
    logic [1:0]        wb_s;
    logic [2:0]        m_s;
    logic [3:0]        ex_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    assign opcode_s = bus.if_id_instr[31:26];

    reg_file #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.mem_wb_reg_write),
        .waddr  (bus.mem_wb_write_reg),
        .wdata  (bus.mem_wb_write_data),
        .raddr1 (bus.if_id_instr[25:21]),
        .raddr2 (bus.if_id_instr[20:16]),
        .rdata1 (rd1_s),
        .rdata2 (rd2_s)
    );

    // Main control decoder; unknown opcodes become a bubble.
    always_comb begin
        wb_s = 2'b00;
        m_s  = 3'b000;
        ex_s = 4'b0000;
        case (opcode_s)
            OP_RTYPE: begin
                wb_s[WB_REG_WRITE]                = 1'b1;
                ex_s[EX_REG_DST]                  = 1'b1;
                ex_s[EX_ALU_OP_HI:EX_ALU_OP_LO]   = ALUOP_FUNCT;
            end
            OP_LW: begin
                wb_s[WB_REG_WRITE]                = 1'b1;
                wb_s[WB_MEM_TO_REG]               = 1'b1;
                m_s[M_MEM_READ]                   = 1'b1;
                ex_s[EX_ALU_OP_HI:EX_ALU_OP_LO]   = ALUOP_ADD;
                ex_s[EX_ALU_SRC]                  = 1'b1;
            end
            OP_SW: begin
                m_s[M_MEM_WRITE]                  = 1'b1;
                ex_s[EX_ALU_OP_HI:EX_ALU_OP_LO]   = ALUOP_ADD;
                ex_s[EX_ALU_SRC]                  = 1'b1;
            end
            OP_BEQ: begin
                m_s[M_BRANCH]                     = 1'b1;
                ex_s[EX_ALU_OP_HI:EX_ALU_OP_LO]   = ALUOP_SUB;
            end
            default: begin
                wb_s = 2'b00;
                m_s  = 3'b000;
                ex_s = 4'b0000;
            end
        endcase
    end

    // ID/EX latch; a flush squashes only the control bundles, data fields always advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.id_ex_wb       <= 2'b00;
            bus.id_ex_m        <= 3'b000;
            bus.id_ex_ex       <= 4'b0000;
            bus.id_ex_npc      <= {DATA_W{1'b0}};
            bus.id_ex_rd1      <= {DATA_W{1'b0}};
            bus.id_ex_rd2      <= {DATA_W{1'b0}};
            bus.id_ex_sign_ext <= {DATA_W{1'b0}};
            bus.id_ex_rt       <= {REG_ADDR_W{1'b0}};
            bus.id_ex_rd       <= {REG_ADDR_W{1'b0}};
        end else begin
            if (bus.id_ex_flush) begin
                bus.id_ex_wb <= 2'b00;
                bus.id_ex_m  <= 3'b000;
                bus.id_ex_ex <= 4'b0000;
            end else begin
                bus.id_ex_wb <= wb_s;
                bus.id_ex_m  <= m_s;
                bus.id_ex_ex <= ex_s;
            end
            bus.id_ex_npc      <= bus.if_id_npc;
            bus.id_ex_rd1      <= rd1_s;
            bus.id_ex_rd2      <= rd2_s;
            bus.id_ex_sign_ext <= sign_ext16(bus.if_id_instr[15:0]);
            bus.id_ex_rt       <= bus.if_id_instr[20:16];
            bus.id_ex_rd       <= bus.if_id_instr[15:11];
        end
    end

endmodule

// File: tb/tb_decode_id.sv
// Directed bench for decode_id: hand-computed expectations checked with immediate assertions.
module tb_decode_id;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    decode_id_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    decode_id dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        bus.mem_wb_reg_write  = en;
        bus.mem_wb_write_reg  = r;
        bus.mem_wb_write_data = d;
    endtask

    task automatic chk_ctrl(input string tag, input logic [1:0] w, input logic [2:0] m, input logic [3:0] e);
        chk({tag, "_wb"}, {30'd0, bus.id_ex_wb}, {30'd0, w});
        chk({tag, "_m"},  {29'd0, bus.id_ex_m},  {29'd0, m});
        chk({tag, "_ex"}, {28'd0, bus.id_ex_ex}, {28'd0, e});
    endtask

    logic [31:0] exp_byp;

    initial begin
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h0000_1234;
`else
        exp_byp = 32'h0000_0000;
`endif
        rst = 1'b1;
        bus.if_id_instr = 32'h0;
        bus.if_id_npc   = 32'h0;
        bus.id_ex_flush = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        #12;
        chk_ctrl("rst0", 2'b00, 3'b000, 4'b0000);
        chk("rst0_npc", bus.id_ex_npc, 32'h0);
        rst = 1'b0;

        // Write $8 = 0xAA
        bus.if_id_instr = 32'h0000_0000; bus.if_id_npc = 32'h4;
        wb(1'b1, 5'd8, 32'h0000_00AA);
        tick();
        // add $9,$8,$8 while writing $5 = 0x55
        bus.if_id_instr = 32'h0108_4820; bus.if_id_npc = 32'h8;
        wb(1'b1, 5'd5, 32'h0000_0055);
        tick();
        chk("add_rd1", bus.id_ex_rd1, 32'h0000_00AA);
        chk("add_rd2", bus.id_ex_rd2, 32'h0000_00AA);
        chk_ctrl("add", 2'b10, 3'b000, 4'b1100);
        chk("add_rd", {27'd0, bus.id_ex_rd}, 32'd9);
        chk("add_npc", bus.id_ex_npc, 32'h8);
        chk("add_sx", bus.id_ex_sign_ext, 32'h0000_4820);

        // lw $2,-4($1)
        wb(1'b0, 5'd0, 32'h0);
        bus.if_id_instr = 32'h8C22_FFFC; bus.if_id_npc = 32'hC;
        tick();
        chk("lw_sx", bus.id_ex_sign_ext, 32'hFFFF_FFFC);
        chk_ctrl("lw", 2'b11, 3'b010, 4'b0001);
        chk("lw_rt", {27'd0, bus.id_ex_rt}, 32'd2);
        chk("lw_rd1", bus.id_ex_rd1, 32'h0);

        // beq
        bus.if_id_instr = 32'h1000_0003; bus.if_id_npc = 32'h10;
        tick();
        chk_ctrl("beq", 2'b00, 3'b100, 4'b0010);
        chk("beq_sx", bus.id_ex_sign_ext, 32'h3);

        // Write to $0 is dropped
        bus.if_id_instr = 32'h0000_0000;
        wb(1'b1, 5'd0, 32'hDEAD_BEEF);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("r0_rd1", bus.id_ex_rd1, 32'h0);
        chk_ctrl("nop", 2'b10, 3'b000, 4'b1100);

        // Same-cycle writeback of $3 and read of rs=$3
        bus.if_id_instr = 32'h0060_0000;
        wb(1'b1, 5'd3, 32'h0000_1234);
        tick();
        chk("byp_rd1", bus.id_ex_rd1, exp_byp);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("after_rd1", bus.id_ex_rd1, 32'h0000_1234);

        // Flushed sw: controls squashed, data latched
        bus.if_id_instr = 32'hAC43_0008; bus.id_ex_flush = 1'b1;
        tick();
        chk_ctrl("flush", 2'b00, 3'b000, 4'b0000);
        chk("flush_sx", bus.id_ex_sign_ext, 32'h8);
        chk("flush_rt", {27'd0, bus.id_ex_rt}, 32'd3);
        chk("flush_rd2", bus.id_ex_rd2, 32'h0000_1234);
        bus.id_ex_flush = 1'b0;
        tick();
        chk_ctrl("sw", 2'b00, 3'b001, 4'b0001);

        // Unknown opcode 0x3F
        bus.if_id_instr = 32'hFC00_0000; bus.if_id_npc = 32'h40;
        tick();
        chk_ctrl("unk", 2'b00, 3'b000, 4'b0000);
        chk("unk_npc", bus.id_ex_npc, 32'h40);

        // Mid-cycle asynchronous reset
        bus.if_id_instr = 32'h0108_4820;
        tick();
        chk("pre_rst_wb", {30'd0, bus.id_ex_wb}, 32'd2);
        #3 rst = 1'b1;
        #1;
        chk_ctrl("arst", 2'b00, 3'b000, 4'b0000);
        chk("arst_rd1", bus.id_ex_rd1, 32'h0);
        chk("arst_npc", bus.id_ex_npc, 32'h0);
        chk("arst_rd", {27'd0, bus.id_ex_rd}, 32'd0);
        #2 rst = 1'b0;
        bus.if_id_instr = 32'h00A8_0000;
        tick();
        chk("post_r5", bus.id_ex_rd1, 32'h0);
        chk("post_r8", bus.id_ex_rd2, 32'h0);
        chk_ctrl("post", 2'b10, 3'b000, 4'b1100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_id.md
Name: decode_id

Overview:
- Instruction-decode stage of the 5-stage pipeline. Sits directly downstream of the IF/ID latch and consumes the fetched instruction and PC+4.
- Contains the 32x32 register file, which is written back from MEM/WB.
- Contains the main control decoder and the sign-extender.
- Registers all results into the ID/EX latch for the execute stage.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, register count (2**REG_ADDR_W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_id_instr  in  32  instruction from IF/ID latch.
- if_id_npc  in  32  PC+4 from IF/ID latch.
- id_ex_flush  in  1  squash; driven from ex_mem_pc_src (taken branch).
- mem_wb_reg_write  in  1  writeback enable.
- mem_wb_write_reg  in  5  writeback register index.
- mem_wb_write_data  in  32  writeback data.
- id_ex_wb  out  2  {reg_write, mem_to_reg}.
- id_ex_m  out  3  {branch, mem_read, mem_write}.
- id_ex_ex  out  4  {reg_dst, alu_op[1:0], alu_src}.
- id_ex_npc  out  32  registered if_id_npc.
- id_ex_rd1  out  32  register file value of rs (instr[25:21]).
- id_ex_rd2  out  32  register file value of rt (instr[20:16]).
- id_ex_sign_ext  out  32  sign-extended instr[15:0].
- id_ex_rt  out  5  instr[20:16].
- id_ex_rd  out  5  instr[15:11].

Behaviour:
- Reset: all id_ex_* outputs go to 0 immediately, asynchronously. All 32 registers are cleared to 0.
- Latency: one cycle. Values decoded from the if_id_* inputs present before edge N appear on id_ex_* after edge N.
- Control decode, by opcode instr[31:26], as {reg_write, mem_to_reg | branch, mem_read, mem_write | reg_dst, alu_op, alu_src}:
  - 0x00 R-type: 1,0 | 0,0,0 | 1,10,0
  - 0x23 lw: 1,1 | 0,1,0 | 0,00,1
  - 0x2B sw: 0,0 | 0,0,1 | 0,00,1
  - 0x04 beq: 0,0 | 1,0,0 | 0,01,0
  - Any other opcode: all controls 0 (bubble). Datapath fields are still latched.
- All-zero instruction (NOP) decodes as R-type writing $0. This is harmless because $0 ignores writes.
- Sign extension: id_ex_sign_ext = {{16{instr[15]}}, instr[15:0]}.
- Register file:
  - Two combinational read ports and one synchronous write port.
  - The write occurs on the rising edge when mem_wb_reg_write=1 and mem_wb_write_reg!=0.
  - Register 0 always reads 0. Writes to index 0 are dropped.
- Flush: when id_ex_flush=1 at an edge, id_ex_wb, id_ex_m and id_ex_ex load 0.
  - The data fields (npc, rd1, rd2, sign_ext, rt, rd) still load normally.
  - The flush has no effect on register file writes in the same cycle.
- Simultaneous writeback and read of the same register: behaviour depends on REGFILE_BYPASS_EN (see Optional Feature).
- Reset asserted mid-operation: state clears immediately. After deassertion the first edge latches the current inputs normally.
- No stall input: the stage advances every cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if a write is active and mem_wb_write_reg equals a nonzero rs or rt, that read port returns mem_wb_write_data in the same cycle (write-before-read).
- Undefined: read ports return the pre-edge register contents. The ID/EX latch captures the old value; software must insert a NOP between writeback and a dependent read.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ;
  - alu_op encodings ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - bit-position constants for the wb, m and ex control bundles.
- One sub-module, reg_file, containing the 32x32 array, the two read ports, the write port and the optional bypass.
- The control decoder and the ID/EX latch stay in decode_id.

Test Plan:
- Reset: assert rst mid-cycle with nonzero outputs -> all id_ex_* = 0 at once; after release, reading $5 returns 0.
- Write $8=0x0000_00AA via writeback. Next cycle instr=0x0108_4820 (add $9,$8,$8) -> id_ex_rd1=id_ex_rd2=0xAA, id_ex_wb=10, id_ex_ex=1100, id_ex_rd=9.
- instr=0x8C22_FFFC (lw $2,-4($1)) -> id_ex_sign_ext=0xFFFF_FFFC, id_ex_wb=11, id_ex_m=010, id_ex_ex=0001, id_ex_rt=2. instr=0x1000_0003 (beq) -> id_ex_m=100, id_ex_ex=0010.
- Writeback $0=0xDEAD_BEEF, then read $0 -> 0.
- Writeback $3=0x1234 in the same cycle as a decode reading rs=$3 -> id_ex_rd1=0x1234 with REGFILE_BYPASS_EN defined; previous value without it.
- id_ex_flush=1 with a valid sw decode (0xAC43_0008) -> id_ex_wb/m/ex = 0, id_ex_sign_ext=0x8 still latched. Unknown opcode 0x3F -> controls 0.
